// File: rtl/cluster_mem_responder_pkg.sv
// ============================================================================
// cluster_mem_responder_pkg
// Shared size encodings, FSM state encoding and line geometry.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cluster_mem_responder_pkg;

  localparam int LINE_BYTES = 16;

  typedef logic [1:0] size_t;
  localparam size_t SZ_B = 2'd0;
  localparam size_t SZ_H = 2'd1;
  localparam size_t SZ_W = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/cluster_mem_responder_if.sv
// ============================================================================
// cluster_mem_responder_if
// 128-bit line port between the responder (master) and DRAM/cache (slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cluster_mem_responder_if;
  logic         o_mem_req;
  logic         o_mem_we;
  logic [31:0]  o_mem_addr;
  logic [127:0] o_mem_wdata;
  logic [15:0]  o_mem_wstrb;
  logic         i_mem_ack;
  logic         i_mem_rvalid;
  logic [127:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    input  i_mem_ack, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    output i_mem_ack, i_mem_rvalid, i_mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/cluster_wstrb_gen.sv
// ============================================================================
// cluster_wstrb_gen
// Size/offset to byte strobes, sub-word lane replication, misalignment flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cluster_wstrb_gen
  import cluster_mem_responder_pkg::*;
(
  input  wire size_t        i_size,
  input  wire logic [3:0]   i_off,
  input  wire logic [31:0]  i_wdata,
  output logic      [15:0]  o_wstrb,
  output logic      [127:0] o_wdata_rep,
  output logic              o_misaligned
);

  always_comb begin
    o_wstrb      = 16'h0000;
    o_wdata_rep  = 128'h0;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_B: begin
        o_wstrb     = 16'h0001 << i_off;
        o_wdata_rep = {16{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_wstrb      = 16'h0003 << i_off;
        o_wdata_rep  = {8{i_wdata[15:0]}};
        o_misaligned = i_off[0];
      end
      default: begin
        o_wstrb      = 16'h000F << i_off;
        o_wdata_rep  = {4{i_wdata}};
        o_misaligned = |i_off[1:0];
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cluster_mem_responder.sv
// ============================================================================
// cluster_mem_responder
// Converts one hart access at a time into a 128-bit line transaction, with a
// one-line read buffer that short-circuits repeated reads of the same line.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cluster_mem_responder
  import cluster_mem_responder_pkg::*;
#(
  parameter int HART_W = 1,
  parameter bit BUF_EN = 1'b1
) (
  input  wire logic              CLK,
  input  wire logic              RST_X,
  input  wire logic              i_req_valid,
  input  wire logic [HART_W-1:0] i_hart,
  input  wire logic              i_iscode,
  input  wire logic              i_isread,
  input  wire logic              i_iswrite,
  input  wire logic [31:0]       i_iaddr,
  input  wire logic [31:0]       i_daddr,
  input  wire logic [31:0]       i_wdata,
  input  wire logic [2:0]        i_ctrl,
  input  wire logic              i_inval,
  output logic                   o_busy,
  output logic [127:0]           o_insn_data,
  output logic [127:0]           o_data_data,
  output logic                   o_is_dram_data,
  output logic [HART_W-1:0]      o_resp_hart,
  output logic                   o_fault,
  cluster_mem_responder_if.master mem
);

  logic [1:0]        state_q, state_d;
  logic              is_code_q, is_code_d;
  logic              is_write_q, is_write_d;
  logic [HART_W-1:0] hart_q, hart_d;
  logic [27:0]       line_q, line_d;
  logic [15:0]       wstrb_q, wstrb_d;
  logic [127:0]      wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              strobe_q, strobe_d;
  logic              fault_q, fault_d;
  logic [HART_W-1:0] resp_hart_q, resp_hart_d;
  logic [127:0]      insn_data_q, insn_data_d;
  logic [127:0]      data_data_q, data_data_d;
  logic              buf_valid_q, buf_valid_d;
  logic [27:0]       buf_tag_q, buf_tag_d;
  logic [127:0]      buf_data_q, buf_data_d;

  logic              w_req_write, w_req_code, w_req_any, w_hit;
  logic [31:0]       w_addr;
  logic [15:0]       w_gen_wstrb;
  logic [127:0]      w_gen_wdata;
  logic              w_gen_mis;
  logic [127:0]      w_merged;
  logic              w_resp_go, w_resp_code, w_resp_fault;
  logic [HART_W-1:0] w_resp_tag;
  logic [127:0]      w_resp_line;
  logic              w_unused_ctrl;

  assign w_unused_ctrl = i_ctrl[2];

  // Writes always address through i_daddr, even if iscode is also set.
  assign w_req_write = i_iswrite;
  assign w_req_code  = i_iscode & ~i_iswrite;
  assign w_req_any   = i_iswrite | i_iscode | i_isread;
  assign w_addr      = w_req_code ? i_iaddr : i_daddr;
  assign w_hit       = BUF_EN && buf_valid_q && (buf_tag_q == w_addr[31:4]) && !i_inval;

  cluster_wstrb_gen u_wstrb_gen (
    .i_size       (i_ctrl[1:0]),
    .i_off        (w_addr[3:0]),
    .i_wdata      (i_wdata),
    .o_wstrb      (w_gen_wstrb),
    .o_wdata_rep  (w_gen_wdata),
    .o_misaligned (w_gen_mis)
  );

  always_comb begin
    w_merged = buf_data_q;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (wstrb_q[b]) w_merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    is_code_d    = is_code_q;
    is_write_d   = is_write_q;
    hart_d       = hart_q;
    line_d       = line_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    strobe_d     = 1'b0;
    fault_d      = 1'b0;
    resp_hart_d  = resp_hart_q;
    insn_data_d  = insn_data_q;
    data_data_d  = data_data_q;
    buf_valid_d  = buf_valid_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    w_resp_go    = 1'b0;
    w_resp_code  = is_code_q;
    w_resp_fault = 1'b0;
    w_resp_tag   = hart_q;
    w_resp_line  = 128'h0;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid && w_req_any) begin
          is_code_d   = w_req_code;
          is_write_d  = w_req_write;
          hart_d      = i_hart;
          line_d      = w_addr[31:4];
          wstrb_d     = w_req_write ? w_gen_wstrb : 16'h0000;
          wdata_d     = w_gen_wdata;
          w_resp_code = w_req_code;
          w_resp_tag  = i_hart;
          if (w_gen_mis) begin
            state_d      = ST_RESP;
            w_resp_go    = 1'b1;
            w_resp_fault = 1'b1;
          end else if (!w_req_write && w_hit) begin
            state_d     = ST_RESP;
            w_resp_go   = 1'b1;
            w_resp_line = buf_data_q;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (mem.i_mem_ack) begin
          if (is_write_q) begin
            state_d   = ST_RESP;
            w_resp_go = 1'b1;
            if (buf_valid_q && (buf_tag_q == line_q)) buf_data_d = w_merged;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem.i_mem_rvalid) begin
          state_d     = ST_RESP;
          w_resp_go   = 1'b1;
          w_resp_line = mem.i_mem_rdata;
          buf_tag_d   = line_q;
          buf_data_d  = mem.i_mem_rdata;
          buf_valid_d = BUF_EN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_resp_go) begin
      strobe_d    = 1'b1;
      fault_d     = w_resp_fault;
      resp_hart_d = w_resp_tag;
      if (w_resp_code) insn_data_d = w_resp_line;
      else             data_data_d = w_resp_line;
    end

    // An external invalidate overrides both refill and write merge.
    if (i_inval) buf_valid_d = 1'b0;

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= ST_IDLE;
      is_code_q   <= 1'b0;
      is_write_q  <= 1'b0;
      hart_q      <= '0;
      line_q      <= 28'h0;
      wstrb_q     <= 16'h0;
      wdata_q     <= 128'h0;
      busy_q      <= 1'b0;
      strobe_q    <= 1'b0;
      fault_q     <= 1'b0;
      resp_hart_q <= '0;
      insn_data_q <= 128'h0;
      data_data_q <= 128'h0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 28'h0;
      buf_data_q  <= 128'h0;
    end else begin
      state_q     <= state_d;
      is_code_q   <= is_code_d;
      is_write_q  <= is_write_d;
      hart_q      <= hart_d;
      line_q      <= line_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      strobe_q    <= strobe_d;
      fault_q     <= fault_d;
      resp_hart_q <= resp_hart_d;
      insn_data_q <= insn_data_d;
      data_data_q <= data_data_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign o_busy          = busy_q;
  assign o_is_dram_data  = strobe_q;
  assign o_fault         = fault_q;
  assign o_resp_hart     = resp_hart_q;
  assign o_insn_data     = insn_data_q;
  assign o_data_data     = data_data_q;
  assign mem.o_mem_req   = (state_q == ST_ISSUE);
  assign mem.o_mem_we    = is_write_q;
  assign mem.o_mem_addr  = {line_q, 4'h0};
  assign mem.o_mem_wdata = wdata_q;
  assign mem.o_mem_wstrb = wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_cluster_mem_responder.sv
// ============================================================================
// tb_cluster_mem_responder
// Directed self-checking bench with a hand-driven memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cluster_mem_responder;

  logic         CLK, RST_X;
  logic         req_valid, iscode, isread, iswrite, inval;
  logic [0:0]   hart;
  logic [31:0]  iaddr, daddr, wdata;
  logic [2:0]   ctrl;
  logic         busy, strobe, fault;
  logic [127:0] insn_data, data_data;
  logic [0:0]   resp_hart;

  cluster_mem_responder_if mem_if ();

  cluster_mem_responder #(.HART_W(1), .BUF_EN(1'b1)) dut (
    .CLK(CLK), .RST_X(RST_X), .i_req_valid(req_valid), .i_hart(hart),
    .i_iscode(iscode), .i_isread(isread), .i_iswrite(iswrite),
    .i_iaddr(iaddr), .i_daddr(daddr), .i_wdata(wdata), .i_ctrl(ctrl),
    .i_inval(inval), .o_busy(busy), .o_insn_data(insn_data),
    .o_data_data(data_data), .o_is_dram_data(strobe), .o_resp_hart(resp_hart),
    .o_fault(fault), .mem(mem_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] L1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] L2 = 128'hDEADBEEF_01020304_A5A55A5A_F00DCAFE;
  localparam logic [127:0] L3 = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;

  logic [127:0] mem_line;
  int           r_strobe_k, r_ack_k, r_rv_k;
  bit           r_req_seen, r_busy_seen, r_unstable, r_busy_at_strobe;
  logic [127:0] r_insn, r_data;
  logic         r_fault, r_we;
  logic [0:0]   r_hart;
  logic [31:0]  r_addr;
  logic [15:0]  r_wstrb;
  logic [127:0] r_wdata;

  // Drives one request and plays the memory side; records what was observed.
  task automatic access(input bit c, input bit r, input bit w,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input logic [2:0] ctl,
                        input logic [0:0] h, input int ack_dly,
                        input int rv_dly, input bit inv);
    int  ack_cnt, rv_cnt;
    bit  acked;
    @(negedge CLK);
    req_valid = 1'b1; iscode = c; isread = r; iswrite = w;
    iaddr = ia; daddr = da; wdata = wd; ctrl = ctl; hart = h;
    r_strobe_k = -1; r_ack_k = -1; r_rv_k = -1;
    r_req_seen = 0; r_busy_seen = 0; r_unstable = 0; r_busy_at_strobe = 0;
    acked = 0; ack_cnt = 0; rv_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      mem_if.i_mem_ack = 1'b0; mem_if.i_mem_rvalid = 1'b0; inval = 1'b0;
      if (busy) r_busy_seen = 1;
      if (mem_if.o_mem_req) begin
        if (!r_req_seen) begin
          r_addr = mem_if.o_mem_addr; r_wstrb = mem_if.o_mem_wstrb;
          r_wdata = mem_if.o_mem_wdata; r_we = mem_if.o_mem_we;
        end else if (r_addr !== mem_if.o_mem_addr || r_wstrb !== mem_if.o_mem_wstrb ||
                     r_wdata !== mem_if.o_mem_wdata || r_we !== mem_if.o_mem_we) begin
          r_unstable = 1;
        end
        r_req_seen = 1;
      end
      if (strobe) begin
        r_strobe_k = k; r_busy_at_strobe = busy;
        r_insn = insn_data; r_data = data_data; r_fault = fault; r_hart = resp_hart;
        break;
      end
      if (mem_if.o_mem_req && !acked) begin
        if (ack_cnt == ack_dly) begin
          mem_if.i_mem_ack = 1'b1; acked = 1; r_ack_k = k;
        end else ack_cnt++;
      end else if (acked && !w && r_rv_k < 0 && k > r_ack_k) begin
        if (rv_cnt == rv_dly) begin
          mem_if.i_mem_rvalid = 1'b1; mem_if.i_mem_rdata = mem_line;
          inval = inv; r_rv_k = k;
        end else rv_cnt++;
      end
    end
    req_valid = 1'b0; iscode = 1'b0; isread = 1'b0; iswrite = 1'b0;
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    req_valid = 0; iscode = 0; isread = 0; iswrite = 0; inval = 0;
    hart = 0; iaddr = 0; daddr = 0; wdata = 0; ctrl = 0;
    mem_if.i_mem_ack = 0; mem_if.i_mem_rvalid = 0; mem_if.i_mem_rdata = 0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, strobe, fault, resp_hart, mem_if.o_mem_req, mem_if.o_mem_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
        {busy, strobe, fault, resp_hart, mem_if.o_mem_req, mem_if.o_mem_we});
    end
    checks++;
    if ({insn_data, data_data, mem_if.o_mem_addr, mem_if.o_mem_wstrb} !== '0) begin
      errors++; $display("FAIL reset_data insn=%h data=%h addr=%h wstrb=%h want 0",
        insn_data, data_data, mem_if.o_mem_addr, mem_if.o_mem_wstrb);
    end
    RST_X = 1'b1;
  endtask

  task automatic test_ignored_req();
    bit seen = 0;
    @(negedge CLK);
    req_valid = 1'b1; daddr = 32'h0000_0040; ctrl = 3'd2;
    repeat (4) begin
      @(negedge CLK);
      if (busy || strobe || mem_if.o_mem_req) seen = 1;
    end
    req_valid = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL no_type_req activity got %0d want 0", seen);
    end
  endtask

  task automatic test_fetch_miss();
    mem_line = L1;
    access(1, 0, 0, 32'h8000_0014, 32'h0, 32'h0, 3'd2, 1'b1, 2, 3, 0);
    checks++;
    if (r_strobe_k !== 8) begin
      errors++; $display("FAIL fetch_miss_latency got %0d want 8", r_strobe_k);
    end
    checks++;
    if (r_insn !== L1) begin
      errors++; $display("FAIL fetch_miss_data got %h want %h", r_insn, L1);
    end
    checks++;
    if (r_addr !== 32'h8000_0010 || r_we !== 1'b0 || r_unstable !== 1'b0) begin
      errors++; $display("FAIL fetch_miss_req addr=%h we=%b unstable=%0d want 80000010/0/0",
        r_addr, r_we, r_unstable);
    end
    checks++;
    if (r_busy_seen !== 1'b1 || r_busy_at_strobe !== 1'b0 || r_hart !== 1'b1) begin
      errors++; $display("FAIL fetch_miss_busy seen=%0d at_strobe=%0d hart=%0d want 1/0/1",
        r_busy_seen, r_busy_at_strobe, r_hart);
    end
  endtask

  task automatic test_fetch_hit();
    mem_line = 128'h0;
    access(1, 0, 0, 32'h8000_001C, 32'h0, 32'h0, 3'd2, 1'b0, 0, 0, 0);
    checks++;
    if (r_strobe_k !== 1 || r_req_seen !== 1'b0 || r_busy_seen !== 1'b0) begin
      errors++; $display("FAIL fetch_hit lat=%0d req=%0d busy=%0d want 1/0/0",
        r_strobe_k, r_req_seen, r_busy_seen);
    end
    checks++;
    if (r_insn !== L1 || r_hart !== 1'b0) begin
      errors++; $display("FAIL fetch_hit_data got %h/%0d want %h/0", r_insn, r_hart, L1);
    end
  endtask

  task automatic test_write_merge();
    access(0, 0, 1, 32'h0, 32'h8000_0013, 32'h0000_00AB, 3'd0, 1'b0, 1, 0, 0);
    checks++;
    if (r_strobe_k !== 3 || r_fault !== 1'b0) begin
      errors++; $display("FAIL byte_write_latency got %0d fault=%0d want 3/0", r_strobe_k, r_fault);
    end
    checks++;
    if (r_wstrb !== 16'h0008 || r_wdata !== {16{8'hAB}} || r_we !== 1'b1 ||
        r_addr !== 32'h8000_0010) begin
      errors++; $display("FAIL byte_write_bus wstrb=%h wdata=%h we=%b addr=%h want 0008/abab../1/80000010",
        r_wstrb, r_wdata, r_we, r_addr);
    end
    access(0, 0, 1, 32'h0, 32'h8000_0016, 32'h0000_1234, 3'd1, 1'b0, 0, 0, 0);
    checks++;
    if (r_wstrb !== 16'h00C0 || r_wdata !== {8{16'h1234}} || r_strobe_k !== 2) begin
      errors++; $display("FAIL half_write wstrb=%h wdata=%h lat=%0d want 00c0/1234../2",
        r_wstrb, r_wdata, r_strobe_k);
    end
    access(1, 0, 0, 32'h8000_0010, 32'h0, 32'h0, 3'd2, 1'b0, 0, 0, 0);
    checks++;
    if (r_strobe_k !== 1 || r_req_seen !== 1'b0 ||
        r_insn !== 128'h00112233_44556677_1234AABB_ABDDEEFF) begin
      errors++; $display("FAIL merged_hit lat=%0d req=%0d data=%h want 1/0/00112233445566771234aabbabddeeff",
        r_strobe_k, r_req_seen, r_insn);
    end
  endtask

  task automatic test_misaligned();
    access(0, 1, 0, 32'h0, 32'h0000_0102, 32'h0, 3'd2, 1'b1, 0, 0, 0);
    checks++;
    if (r_strobe_k !== 1 || r_fault !== 1'b1 || r_req_seen !== 1'b0 || r_busy_seen !== 1'b0) begin
      errors++; $display("FAIL misaligned lat=%0d fault=%0d req=%0d busy=%0d want 1/1/0/0",
        r_strobe_k, r_fault, r_req_seen, r_busy_seen);
    end
    checks++;
    if (r_data !== 128'h0 || r_hart !== 1'b1) begin
      errors++; $display("FAIL misaligned_data got %h/%0d want 0/1", r_data, r_hart);
    end
  endtask

  task automatic test_inval_refill();
    mem_line = L2;
    access(0, 1, 0, 32'h0, 32'h0000_0200, 32'h0, 3'd2, 1'b0, 0, 0, 1);
    checks++;
    if (r_strobe_k !== 3 || r_data !== L2) begin
      errors++; $display("FAIL inval_read lat=%0d data=%h want 3/%h", r_strobe_k, r_data, L2);
    end
    access(0, 1, 0, 32'h0, 32'h0000_0204, 32'h0, 3'd2, 1'b0, 0, 0, 0);
    checks++;
    if (r_req_seen !== 1'b1 || r_strobe_k !== 3 || r_addr !== 32'h0000_0200) begin
      errors++; $display("FAIL inval_next_miss req=%0d lat=%0d addr=%h want 1/3/00000200",
        r_req_seen, r_strobe_k, r_addr);
    end
  endtask

  task automatic test_reset_abort();
    bit late_strobe = 0;
    @(negedge CLK);
    req_valid = 1'b1; iscode = 1'b1; iaddr = 32'h0000_0300; ctrl = 3'd2;
    @(negedge CLK);
    mem_if.i_mem_ack = 1'b1;
    @(negedge CLK);
    mem_if.i_mem_ack = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_in_wait busy got %0d want 1", busy);
    end
    #2 RST_X = 1'b0;
    req_valid = 1'b0; iscode = 1'b0;
    #1;
    checks++;
    if ({busy, strobe, mem_if.o_mem_req} !== 3'b0 || insn_data !== 128'h0 ||
        data_data !== 128'h0 || mem_if.o_mem_addr !== 32'h0) begin
      errors++; $display("FAIL abort_reset_outs busy=%0d strobe=%0d req=%0d insn=%h data=%h addr=%h want 0",
        busy, strobe, mem_if.o_mem_req, insn_data, data_data, mem_if.o_mem_addr);
    end
    @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    mem_if.i_mem_rvalid = 1'b1; mem_if.i_mem_rdata = L2;
    @(negedge CLK);
    mem_if.i_mem_rvalid = 1'b0;
    repeat (3) begin
      if (strobe || busy) late_strobe = 1;
      @(negedge CLK);
    end
    checks++;
    if (late_strobe !== 1'b0 || insn_data !== 128'h0) begin
      errors++; $display("FAIL abort_late_rvalid activity=%0d insn=%h want 0/0", late_strobe, insn_data);
    end
    mem_line = L3;
    access(1, 0, 0, 32'h8000_0010, 32'h0, 32'h0, 3'd2, 1'b0, 0, 0, 0);
    checks++;
    if (r_req_seen !== 1'b1 || r_insn !== L3 || r_strobe_k !== 3) begin
      errors++; $display("FAIL abort_next_miss req=%0d data=%h lat=%0d want 1/%h/3",
        r_req_seen, r_insn, r_strobe_k, L3);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_req();
    test_fetch_miss();
    test_fetch_hit();
    test_write_merge();
    test_misaligned();
    test_inval_refill();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
